// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, two writeback ports, issue/flush and scoreboard status.
// The master drives addresses, writes and issue; the slave (register file) returns data and busy state.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
);
  logic [NRD*AW-1:0]   rd_addr_i;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NRD-1:0]      rd_busy_o;
  logic                w0_en_i;
  logic [AW-1:0]       w0_addr_i;
  logic [XLEN-1:0]     w0_data_i;
  logic                w1_en_i;
  logic [AW-1:0]       w1_addr_i;
  logic [XLEN-1:0]     w1_data_i;
  logic                iss_en_i;
  logic [AW-1:0]       iss_addr_i;
  logic                flush_i;
  logic [AW:0]         busy_cnt_o;

  modport master (
    output rd_addr_i, w0_en_i, w0_addr_i, w0_data_i, w1_en_i, w1_addr_i, w1_data_i,
           iss_en_i, iss_addr_i, flush_i,
    input  rd_data_o, rd_busy_o, busy_cnt_o
  );

  modport slave (
    input  rd_addr_i, w0_en_i, w0_addr_i, w0_data_i, w1_en_i, w1_addr_i, w1_data_i,
           iss_en_i, iss_addr_i, flush_i,
    output rd_data_o, rd_busy_o, busy_cnt_o
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with NRD bypassed read ports, two writeback ports (w1 has priority)
// and a per-register busy scoreboard driven by issue, writeback and flush.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_sb_if.slave bus
);
  localparam int NREGS = 1 << AW;

  logic [XLEN-1:0]     mem_q [NREGS];
  logic [XLEN-1:0]     mem_d [NREGS];
  logic [NREGS-1:0]    busy_q, busy_d;
  logic                w0_we, w1_we;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [AW:0]         cnt;

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Returns {busy, data} for one read port after writeback bypass.
  function automatic logic [XLEN:0] rd_lookup(input logic [AW-1:0] a);
    logic [XLEN-1:0] d;
    logic            b;
    logic            h0, h1;
    h0 = bus.w0_en_i && (bus.w0_addr_i == a);
    h1 = bus.w1_en_i && (bus.w1_addr_i == a);
    d  = mem_q[a];
    b  = busy_q[a];
    if (h1)      d = bus.w1_data_i;
    else if (h0) d = bus.w0_data_i;
    if (h0 || h1) b = 1'b0;
    if (is_zero_reg(a)) begin
      d = '0;
      b = 1'b0;
    end
    return {b, d};
  endfunction

  assign w0_we = bus.w0_en_i && !is_zero_reg(bus.w0_addr_i);
  assign w1_we = bus.w1_en_i && !is_zero_reg(bus.w1_addr_i);

  always_comb begin
    mem_d = mem_q;
    if (w0_we) mem_d[bus.w0_addr_i] = bus.w0_data_i;
    if (w1_we) mem_d[bus.w1_addr_i] = bus.w1_data_i;
  end

  // A new producer (issue) overrides a same-cycle writeback of the previous one.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (bus.flush_i)
        busy_d[r] = 1'b0;
      else if (bus.iss_en_i && (bus.iss_addr_i == AW'(r)))
        busy_d[r] = 1'b1;
      else if ((w0_we && (bus.w0_addr_i == AW'(r))) || (w1_we && (bus.w1_addr_i == AW'(r))))
        busy_d[r] = 1'b0;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) mem_q[r] <= mem_d[r];
      busy_q <= busy_d;
    end
  end

  always_comb begin
    logic [XLEN:0] res;
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      res = rd_lookup(bus.rd_addr_i[k*AW +: AW]);
      rd_data[k*XLEN +: XLEN] = res[XLEN-1:0];
      rd_busy[k]              = res[XLEN];
    end
  end

  always_comb begin
    cnt = '0;
    for (int r = 0; r < NREGS; r++) cnt = cnt + (AW+1)'(busy_q[r]);
  end

  // Outputs are held at zero while reset is asserted, independent of stored state.
  assign bus.rd_data_o  = rst_n ? rd_data : '0;
  assign bus.rd_busy_o  = rst_n ? rd_busy : '0;
  assign bus.busy_cnt_o = rst_n ? cnt : '0;
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-read-port, dual-write-port integer register file with an integrated per-register scoreboard (busy bits) for the core's issue logic.
- Decode reads source operands through NRD combinational ports with same-cycle write bypass.
- Issue marks destination registers pending; the two writeback paths (w0 = ALU/EX, w1 = LSU/late) write data and clear pending.
- Register 0 is optionally hardwired to zero.

Parameters:
XLEN, 32, data width in bits
AW, 5, register address width; NREGS = 2**AW entries
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0, is never written, and is never busy; 0 = register 0 is ordinary

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
rd_addr_i  input  NRD*AW  read addresses; port k at bits [k*AW +: AW]
rd_data_o  output  NRD*XLEN  read data; port k at bits [k*XLEN +: XLEN]
rd_busy_o  output  NRD  port k: source register still pending after bypass
w0_en_i  input  1  write port 0 enable
w0_addr_i  input  AW  write port 0 address
w0_data_i  input  XLEN  write port 0 data
w1_en_i  input  1  write port 1 enable (priority port)
w1_addr_i  input  AW  write port 1 address
w1_data_i  input  XLEN  write port 1 data
iss_en_i  input  1  issue: mark iss_addr_i pending
iss_addr_i  input  AW  destination register of issuing instruction
flush_i  input  1  clear all busy bits (pipeline flush)
busy_cnt_o  output  AW+1  number of currently pending registers

Behaviour:
- Reset is decided: rst_n is synchronous and active-low; clock is clk.
- On a clk edge with rst_n=0:
  - All NREGS data entries are set to 0, including the highest-index entry.
  - All busy bits are set to 0.
  - Write, issue and flush inputs are ignored that cycle.
- While rst_n=0: rd_data_o=0, rd_busy_o=0, busy_cnt_o=0 (forced combinationally).
- Read path (combinational, 0 latency), per port k with address a, first match wins:
  1. ZERO_REG=1 and a==0 -> data 0, busy 0.
  2. w1_en_i and w1_addr_i==a -> w1_data_i.
  3. w0_en_i and w0_addr_i==a -> w0_data_i.
  4. Otherwise -> stored entry a.
- rd_busy_o[k] = busy_q[a] AND NOT (w0 hit on a OR w1 hit on a). A same-cycle writeback therefore un-busies the read.
- rd_busy_o ignores a same-cycle issue; the issuing instruction reads its sources before its destination becomes pending.
- Write path (rising edge):
  - w0 and w1 each write when enabled.
  - Equal addresses on both ports: w1 data is stored.
  - ZERO_REG=1 and address 0: the write is dropped.
- Scoreboard next state for each register r, priority order:
  1. flush_i -> 0.
  2. iss_en_i and iss_addr_i==r -> 1 (a new producer beats a same-cycle writeback of the old one).
  3. A w0 or w1 write to r -> 0.
  4. Otherwise hold.
- With ZERO_REG=1, busy bit 0 is constant 0 and issue to r0 is ignored.
- flush_i affects busy bits only; data writes in the same cycle still occur.
- A writeback to a non-busy register is legal: data is written and the busy bit stays 0.
- busy_cnt_o is a combinational popcount of the registered busy bits (current state, not next). Range 0..NREGS, or 0..NREGS-1 with ZERO_REG=1.
- No internal X: all read muxes are defined for every address value.

Test Plan:
- Reset (default params), then read every address on both ports -> all rd_data_o=0, rd_busy_o=0, busy_cnt_o=0. Includes address 31.
- Write w0 addr 5 = 0xDEADBEEF while port0 reads 5 in the same cycle -> port0 = 0xDEADBEEF that cycle (bypass) and the next (stored). Write addr 0 = 0x1234 -> reads 0.
- Same cycle: w0 addr 7 = 0x11111111 and w1 addr 7 = 0x22222222 -> bypass and stored value both 0x22222222.
- Issue addr 3 -> next cycle rd_busy_o=1 for addr 3, busy_cnt_o=1.
  - w1 writes 3 = 0xA5A5A5A5 -> that cycle busy 0 with data 0xA5A5A5A5; next cycle busy_cnt_o=0.
  - Issue 3 together with w0 writing 3 -> busy stays 1.
- Issue regs 1, 2, 4 on successive cycles -> busy_cnt_o steps 1, 2, 3.
  - Then flush_i together with w0 writing 2 = 0x5 -> busy_cnt_o=0 next cycle, and reg 2 reads 0x5.
- Busy regs 1 and 9, then pulse rst_n=0 for one cycle mid-stream with w0_en_i=1 -> all data 0 and busy 0 afterwards; the write is discarded.
- NRD=3, ZERO_REG=0 -> write r0 = 0x77 via w1, then read r0 on all three ports -> 0x77. Issue r0 -> busy 1.
